doce_tx_eth_framer: RTL and testbench

//  Sits directly upstream of the MAC/ID table on the transport-layer TX path. Accepts DoCE payload frames

---
 rtl/doce_tx_eth_framer.sv | 156 +++++++++++++++
 tb/tb_doce_tx_eth_framer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/doce_tx_eth_framer.sv
// doce_tx_eth_framer
// Framer on the DoCE transport TX path. It takes payload frames tagged with a
// destination node ID and drives that ID to the MAC/ID table. It then
// registers the MAC address the table returns and emits two header beats
// (16 bytes) followed by the payload. Frames whose node ID is out of range
// are discarded and counted.
//
// Ports
//   clk, reset_n              clock; asynchronous active-low reset
//   s_axis_txd_*              payload in (tuser = destination ID, first beat)
//   trans_axis_txd_tuser      destination ID sent to the MAC/ID table
//   tx_dst_mac_addr           table result, valid one cycle after the ID
//   src_mac_addr              MAC address of this node (static)
//   m_axis_txd_*              framed stream out (registered valid/data)
//   frame_cnt                 frames sent (wraps)
//   drop_cnt                  frames dropped (saturates)
module doce_tx_eth_framer #(
    parameter int          NUM_NODES = 4,
    parameter logic [15:0] ETHERTYPE = 16'h88B5,
    parameter logic [3:0]  LOCAL_ID  = 4'd0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [63:0] s_axis_txd_tdata,
    input  logic [7:0]  s_axis_txd_tkeep,
    input  logic [3:0]  s_axis_txd_tuser,
    input  logic        s_axis_txd_tlast,
    input  logic        s_axis_txd_tvalid,
    output logic        s_axis_txd_tready,
    output logic [3:0]  trans_axis_txd_tuser,
    input  logic [47:0] tx_dst_mac_addr,
    input  logic [47:0] src_mac_addr,
    output logic [63:0] m_axis_txd_tdata,
    output logic [7:0]  m_axis_txd_tkeep,
    output logic        m_axis_txd_tlast,
    output logic        m_axis_txd_tvalid,
    input  logic        m_axis_txd_tready,
    output logic [31:0] frame_cnt,
    output logic [15:0] drop_cnt
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOOKUP, S_WAIT, S_HDR0, S_HDR1, S_PAYLOAD, S_DROP
    } state_t;

    localparam logic [4:0] NODE_LIM = 5'(NUM_NODES);

    state_t      state_q;
    logic [3:0]  dst_id_q;
    logic [47:0] dst_mac_q;
    logic [63:0] m_data_q;
    logic [7:0]  m_keep_q;
    logic        m_last_q;
    logic        m_valid_q;
    logic [31:0] frame_cnt_q;
    logic [15:0] drop_cnt_q;

    logic        out_free, out_hs, s_hs, id_ok;
    logic [63:0] hdr0_beat, hdr1_beat;

    // Output register can take a new beat when empty or draining this cycle.
    assign out_free = !m_valid_q || m_axis_txd_tready;
    assign out_hs   = m_valid_q && m_axis_txd_tready;
    assign s_axis_txd_tready = (state_q == S_DROP) ||
                               ((state_q == S_PAYLOAD) && out_free);
    assign s_hs  = s_axis_txd_tvalid && s_axis_txd_tready;
    assign id_ok = {1'b0, s_axis_txd_tuser} < NODE_LIM;

    // Byte 0 goes on the wire first, so MAC fields are laid out MSB byte first.
    always_comb begin
        hdr0_beat = '0;
        hdr1_beat = '0;
        for (int k = 0; k < 6; k++)
            hdr0_beat[8*k +: 8] = dst_mac_q[8*(5-k) +: 8];
        hdr0_beat[55:48] = src_mac_addr[47:40];
        hdr0_beat[63:56] = src_mac_addr[39:32];
        for (int k = 0; k < 4; k++)
            hdr1_beat[8*k +: 8] = src_mac_addr[8*(3-k) +: 8];
        hdr1_beat[39:32] = ETHERTYPE[15:8];
        hdr1_beat[47:40] = ETHERTYPE[7:0];
        hdr1_beat[55:48] = {4'b0, LOCAL_ID};
        hdr1_beat[63:56] = {4'b0, dst_id_q};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            dst_id_q    <= '0;
            dst_mac_q   <= '0;
            m_data_q    <= '0;
            m_keep_q    <= '0;
            m_last_q    <= 1'b0;
            m_valid_q   <= 1'b0;
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            // Drained beat; a load further down re-asserts valid in the same cycle.
            if (out_hs) m_valid_q <= 1'b0;
            if (out_hs && m_last_q) frame_cnt_q <= frame_cnt_q + 32'd1;

            case (state_q)
                S_IDLE: begin
                    // First beat is only inspected here; it is consumed later.
                    if (s_axis_txd_tvalid) begin
                        if (id_ok) begin
                            dst_id_q <= s_axis_txd_tuser;
                            state_q  <= S_LOOKUP;
                        end else begin
                            state_q  <= S_DROP;
                        end
                    end
                end
                S_LOOKUP: state_q <= S_WAIT;
                S_WAIT: begin
                    dst_mac_q <= tx_dst_mac_addr;
                    state_q   <= S_HDR0;
                end
                S_HDR0: if (out_free) begin
                    m_data_q  <= hdr0_beat;
                    m_keep_q  <= 8'hFF;
                    m_last_q  <= 1'b0;
                    m_valid_q <= 1'b1;
                    state_q   <= S_HDR1;
                end
                S_HDR1: if (out_free) begin
                    m_data_q  <= hdr1_beat;
                    m_keep_q  <= 8'hFF;
                    m_last_q  <= 1'b0;
                    m_valid_q <= 1'b1;
                    state_q   <= S_PAYLOAD;
                end
                S_PAYLOAD: if (s_hs) begin
                    m_data_q  <= s_axis_txd_tdata;
                    m_keep_q  <= s_axis_txd_tkeep;
                    m_last_q  <= s_axis_txd_tlast;
                    m_valid_q <= 1'b1;
                    if (s_axis_txd_tlast) state_q <= S_IDLE;
                end
                S_DROP: if (s_hs && s_axis_txd_tlast) begin
                    if (drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign trans_axis_txd_tuser = dst_id_q;
    assign m_axis_txd_tdata     = m_data_q;
    assign m_axis_txd_tkeep     = m_keep_q;
    assign m_axis_txd_tlast     = m_last_q;
    assign m_axis_txd_tvalid    = m_valid_q;
    assign frame_cnt            = frame_cnt_q;
    assign drop_cnt             = drop_cnt_q;

endmodule

// File: tb/tb_doce_tx_eth_framer.sv
module tb_doce_tx_eth_framer;

    localparam int          NUM_NODES = 4;
    localparam logic [15:0] ETYPE     = 16'h88B5;
    localparam logic [7:0]  LOCAL     = 8'h00;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [63:0] s_tdata = '0;
    logic [7:0]  s_tkeep = '0;
    logic [3:0]  s_tuser = '0;
    logic        s_tlast = 1'b0;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic [3:0]  trans_tuser;
    logic [47:0] dst_mac = '0;
    logic [47:0] src_mac = 48'h112233445566;
    logic [63:0] m_tdata;
    logic [7:0]  m_tkeep;
    logic        m_tlast;
    logic        m_tvalid;
    logic        m_tready = 1'b1;
    logic [31:0] frame_cnt;
    logic [15:0] drop_cnt;

    doce_tx_eth_framer #(.NUM_NODES(NUM_NODES), .ETHERTYPE(ETYPE), .LOCAL_ID(4'd0)) dut (
        .clk(clk), .reset_n(reset_n),
        .s_axis_txd_tdata(s_tdata), .s_axis_txd_tkeep(s_tkeep), .s_axis_txd_tuser(s_tuser),
        .s_axis_txd_tlast(s_tlast), .s_axis_txd_tvalid(s_tvalid), .s_axis_txd_tready(s_tready),
        .trans_axis_txd_tuser(trans_tuser), .tx_dst_mac_addr(dst_mac), .src_mac_addr(src_mac),
        .m_axis_txd_tdata(m_tdata), .m_axis_txd_tkeep(m_tkeep), .m_axis_txd_tlast(m_tlast),
        .m_axis_txd_tvalid(m_tvalid), .m_axis_txd_tready(m_tready),
        .frame_cnt(frame_cnt), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct { logic [63:0] d; logic [7:0] k; logic l; } beat_t;
    beat_t       exp_q[$];
    logic [47:0] mac_tbl[16];
    int          n_cmp = 0, n_bad = 0;
    int          exp_frames = 0, exp_drops = 0;
    logic [3:0]  last_good = 4'd0;
    bit          rand_ready = 1'b0;
    bit          in_rst = 1'b1;

    // MAC/ID table: registered lookup
    always @(posedge clk) dst_mac <= mac_tbl[trans_tuser];

    // Downstream ready pattern
    initial forever begin
        @(posedge clk); #1;
        m_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor / scoreboard
    initial begin : monitor
        bit          stall_prev = 1'b0;
        logic [72:0] held = '0;
        forever begin
            @(negedge clk);
            if (in_rst) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) check("stall_hold", {55'b0, m_tvalid, m_tdata, m_tkeep, m_tlast} >> 0,
                                      {55'b0, 1'b1, held});
                if (m_tvalid && m_tready) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL unexpected_beat: got %h/%h/%b expected none", m_tdata, m_tkeep, m_tlast);
                    end else begin
                        beat_t e;
                        e = exp_q.pop_front();
                        check("beat", {m_tdata}, {e.d});
                        check("beat_keep_last", {55'b0, m_tkeep, m_tlast}, {55'b0, e.k, e.l});
                    end
                end
                stall_prev = m_tvalid && !m_tready;
                held = {m_tdata, m_tkeep, m_tlast};
            end
        end
    end

    function automatic logic [63:0] pack8(input logic [7:0] b[16], input int base);
        logic [63:0] r = '0;
        for (int k = 0; k < 8; k++) r = r | (64'(b[base + k]) << (8 * k));
        return r;
    endfunction

    // Reference: a good frame is 16 header bytes on the wire then payload unchanged.
    task automatic push_expected(input logic [3:0] id, input logic [63:0] d[$],
                                 input logic [7:0] lastkeep);
        logic [7:0]  b[16];
        logic [47:0] mac;
        mac = mac_tbl[id];
        for (int k = 0; k < 6; k++) b[k] = 8'((mac >> (40 - 8 * k)) & 48'hFF);
        b[6] = 8'(src_mac >> 40);
        b[7] = 8'(src_mac >> 32);
        for (int k = 0; k < 4; k++) b[8 + k] = 8'((src_mac >> (24 - 8 * k)) & 48'hFF);
        b[12] = ETYPE[15:8];
        b[13] = ETYPE[7:0];
        b[14] = LOCAL;
        b[15] = {4'b0, id};
        exp_q.push_back('{pack8(b, 0), 8'hFF, 1'b0});
        exp_q.push_back('{pack8(b, 8), 8'hFF, 1'b0});
        for (int i = 0; i < d.size(); i++)
            exp_q.push_back('{d[i], (i == d.size() - 1) ? lastkeep : 8'hFF, i == d.size() - 1});
    endtask

    // Drive one frame; abort_at >= 0 pulses reset before that beat.
    task automatic send_frame(input logic [3:0] id, input int nb, input logic [7:0] lastkeep,
                              input int abort_at);
        logic [63:0] d[$];
        int t;
        bit good;
        good = (int'(id) < NUM_NODES);
        for (int i = 0; i < nb; i++) d.push_back({$urandom(), $urandom()});
        if (good) begin
            push_expected(id, d, lastkeep);
            exp_frames++;
            last_good = id;
        end else if (exp_drops < 16'hFFFF) begin
            exp_drops++;
        end
        for (int i = 0; i < nb; i++) begin
            if (i == abort_at) begin
                reset_n = 1'b0; in_rst = 1'b1; s_tvalid = 1'b0;
                @(negedge clk);
                check("rst_m_tvalid", {63'b0, m_tvalid}, 64'd0);
                check("rst_s_tready", {63'b0, s_tready}, 64'd0);
                check("rst_frame_cnt", {32'b0, frame_cnt}, 64'd0);
                exp_q.delete();
                exp_frames = 0; exp_drops = 0; last_good = 4'd0;
                @(posedge clk); #1;
                reset_n = 1'b1; in_rst = 1'b0;
                return;
            end
            s_tdata = d[i];
            s_tkeep = (i == nb - 1) ? lastkeep : 8'hFF;
            s_tlast = (i == nb - 1);
            s_tuser = id;
            s_tvalid = 1'b1;
            t = 0;
            do begin @(negedge clk); t++; end while (!s_tready && t < 2000);
            if (!s_tready) begin
                n_cmp++; n_bad++;
                $display("FAIL input_timeout: got no s_tready expected handshake");
                s_tvalid = 1'b0;
                return;
            end
            if (!good && i > 0) check("drop_rate", 64'(t), 64'd1);
            @(posedge clk); #1;
        end
        s_tvalid = 1'b0; s_tlast = 1'b0;
        if (!good) check("trans_unchanged", {60'b0, trans_tuser}, {60'b0, last_good});
    endtask

    task automatic drain_and_check(input string tag);
        int t = 0;
        while (exp_q.size() != 0 && t < 3000) begin @(negedge clk); t++; end
        if (exp_q.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL %s_drain: got %0d beats left expected 0", tag, exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(negedge clk);
        check({tag, "_frame_cnt"}, {32'b0, frame_cnt}, 64'(exp_frames));
        check({tag, "_drop_cnt"}, {48'b0, drop_cnt}, 64'(exp_drops));
    endtask

    initial begin
        logic [7:0] keeps[8];
        keeps = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF};
        for (int i = 0; i < 16; i++) mac_tbl[i] = {$urandom(), $urandom()} & 48'hFFFF_FFFF_FFFF;
        mac_tbl[2] = 48'h0A0B0C0D0E0F;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_m_tvalid", {63'b0, m_tvalid}, 64'd0);
        check("reset_s_tready", {63'b0, s_tready}, 64'd0);
        check("reset_frame_cnt", {32'b0, frame_cnt}, 64'd0);
        check("reset_drop_cnt", {48'b0, drop_cnt}, 64'd0);
        check("reset_trans", {60'b0, trans_tuser}, 64'd0);
        check("reset_m_tdata", m_tdata, 64'd0);
        @(posedge clk); #1;
        reset_n = 1'b1; in_rst = 1'b0;
        repeat (2) @(posedge clk); #1;

        // Known header for ID 2: byte0..5 = 0A..0F, byte6 = 11, byte7 = 22
        send_frame(4'd2, 3, 8'hFF, -1);
        drain_and_check("t1");
        // Out-of-range ID is dropped
        send_frame(4'd7, 4, 8'hFF, -1);
        drain_and_check("t2");
        // Single-beat payload with partial keep
        send_frame(4'd1, 1, 8'h0F, -1);
        drain_and_check("t4");

        // Random frames under random backpressure
        rand_ready = 1'b1;
        for (int f = 0; f < 14; f++) begin
            send_frame(4'($urandom_range(0, 7)), int'($urandom_range(1, 20)),
                       keeps[$urandom_range(0, 7)], -1);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
        drain_and_check("t3");
        rand_ready = 1'b0;

        // Reset during payload, then a clean frame
        send_frame(4'd3, 6, 8'hFF, 2);
        repeat (2) @(posedge clk); #1;
        send_frame(4'd0, 4, 8'h3F, -1);
        drain_and_check("t5");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global guard against a hung run
    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected completion");
        $fatal(1, "timeout");
    end

endmodule
